// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax BRAM datapath: row geometry,
// loader state encoding and the packed BRAM row type.
package softmax_pkg;

    localparam int unsigned MODE_W = 4;
    localparam int unsigned X_W    = 1024;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned IN_W   = 32;
    localparam int unsigned BRAM_W = MODE_W + X_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_START = 3'd4,
        ST_WBH   = 3'd5,
        ST_WBL   = 3'd6,
        ST_DONE  = 3'd7
    } loader_state_t;

    typedef logic [BRAM_W-1:0] bram_row_t;

endpackage

// File: rtl/row_packer.sv
// Row assembly for the BRAM row loader: captures the mode nibble from the
// header beat and inserts each data beat little-endian into the payload.
module row_packer #(
    parameter int unsigned IN_W   = softmax_pkg::IN_W,
    parameter int unsigned X_W    = softmax_pkg::X_W,
    parameter int unsigned MODE_W = softmax_pkg::MODE_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_clear,
    input  logic                  i_hdr_we,
    input  logic                  i_beat_we,
    input  logic [IN_W-1:0]       i_data,
    output logic [MODE_W+X_W-1:0] o_row,
    output logic                  o_last_beat
);
    import softmax_pkg::*;

    localparam int unsigned BEATS  = X_W / IN_W;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [BEAT_W-1:0] beat_q;
    logic [MODE_W-1:0] mode_q;
    logic [X_W-1:0]    x_q;

    // Beat counter and row register; the header restarts the beat count.
    always_ff @(posedge i_clk) begin
        if (i_rst || (i_en && i_clear)) begin
            beat_q <= '0;
            mode_q <= '0;
            x_q    <= '0;
        end else if (i_en) begin
            if (i_hdr_we) begin
                mode_q <= i_data[MODE_W-1:0];
                beat_q <= '0;
            end else if (i_beat_we) begin
                x_q[int'(beat_q)*IN_W +: IN_W] <= i_data;
                beat_q <= o_last_beat ? '0 : beat_q + 1'b1;
            end
        end
    end

    // Packed row and final-beat flag for the loader FSM.
    always_comb begin
        o_row       = {mode_q, x_q};
        o_last_beat = (beat_q == BEAT_W'(BEATS - 1));
    end

endmodule

// File: rtl/bram_row_loader.sv
// Host-stream to BRAM port A row loader. Packs header+data beats into one
// BRAM row each, writes it, then hands port A to the softmax sequencer via
// a start pulse and waits for its busy handshake before reporting done.
module bram_row_loader #(
    parameter int unsigned IN_W   = softmax_pkg::IN_W,
    parameter int unsigned X_W    = softmax_pkg::X_W,
    parameter int unsigned MODE_W = softmax_pkg::MODE_W,
    parameter int unsigned ADDR_W = softmax_pkg::ADDR_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_load,
    input  logic [ADDR_W-1:0]     i_depth,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic [IN_W-1:0]       i_s_data,
    input  logic                  i_s_last,
    output logic                  o_cena,
    output logic                  o_wea,
    output logic [ADDR_W-1:0]     o_addra,
    output logic [MODE_W+X_W-1:0] o_dina,
    output logic                  o_porta_sel,
    output logic                  o_start,
    input  logic                  i_busy,
    output logic                  o_done,
    output logic                  o_err
);
    import softmax_pkg::*;

    loader_state_t         state_q;
    logic [ADDR_W-1:0]     row_q;
    logic [ADDR_W-1:0]     depth_q;
    logic                  err_q;
    logic                  xfer;
    logic                  last_beat;
    logic                  row_is_last;
    logic                  pk_clear;
    logic                  pk_hdr_we;
    logic                  pk_beat_we;
    logic [MODE_W+X_W-1:0] row_word;

    // Handshake and packer strobes derived from the current state.
    always_comb begin
        o_s_ready   = i_en && ((state_q == ST_HDR) || (state_q == ST_DATA));
        xfer        = i_s_valid && o_s_ready;
        row_is_last = (row_q == depth_q);
        pk_clear    = i_en && (state_q == ST_IDLE) && i_load;
        pk_hdr_we   = xfer && (state_q == ST_HDR);
        pk_beat_we  = xfer && (state_q == ST_DATA);
    end

    row_packer #(
        .IN_W   (IN_W),
        .X_W    (X_W),
        .MODE_W (MODE_W)
    ) u_packer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_clear     (pk_clear),
        .i_hdr_we    (pk_hdr_we),
        .i_beat_we   (pk_beat_we),
        .i_data      (i_s_data),
        .o_row       (row_word),
        .o_last_beat (last_beat)
    );

    // Job sequencing; any mis-framed beat aborts the job with a sticky error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else if (i_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_load) begin
                        depth_q <= i_depth;
                        row_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        if (i_s_last) begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        if (last_beat) begin
                            if (i_s_last != row_is_last) begin
                                err_q   <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_WRITE;
                            end
                        end else if (i_s_last) begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (row_is_last) begin
                        state_q <= ST_START;
                    end else begin
                        row_q   <= row_q + 1'b1;
                        state_q <= ST_HDR;
                    end
                end
                ST_START: state_q <= ST_WBH;
                ST_WBH:   if (i_busy)  state_q <= ST_WBL;
                ST_WBL:   if (!i_busy) state_q <= ST_DONE;
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // Port A drive and pulse outputs; pulses are masked while stalled.
    always_comb begin
        o_cena      = i_en && (state_q == ST_WRITE);
        o_wea       = i_en && (state_q == ST_WRITE);
        o_addra     = row_q;
        o_dina      = row_word;
        o_start     = i_en && (state_q == ST_START);
        o_done      = i_en && (state_q == ST_DONE);
        o_porta_sel = !((state_q == ST_START) || (state_q == ST_WBH) || (state_q == ST_WBL));
        o_err       = err_q;
    end

endmodule

// File: tb/tb_bram_row_loader.sv
// Scoreboard bench for bram_row_loader: stimulus pushes expected BRAM writes,
// a monitor pops and compares them as the DUT writes port A.
module tb_bram_row_loader;
    import softmax_pkg::*;

    logic            clk = 1'b0;
    logic            rst, en, load, s_valid, s_last, busy;
    logic [7:0]      depth;
    logic [31:0]     s_data;
    logic            s_ready, cena, wea, porta_sel, start, done, err;
    logic [7:0]      addra;
    bram_row_t       dina;

    typedef struct {
        logic [7:0] addr;
        bram_row_t  data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  n_start = 0;
    int  n_done = 0;
    int  cyc = 0;
    int  last_wr_cyc = -100;

    bram_row_loader #(
        .IN_W(32), .X_W(1024), .MODE_W(4), .ADDR_W(8)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_load(load), .i_depth(depth),
        .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data), .i_s_last(s_last),
        .o_cena(cena), .o_wea(wea), .o_addra(addra), .o_dina(dina),
        .o_porta_sel(porta_sel), .o_start(start), .i_busy(busy),
        .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Pops the expected write whenever port A is written; also tracks pulses.
    task automatic monitor();
        wr_t e;
        int  bad;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (cena || wea) begin
                    chk("wea_with_cena", {cena, wea}, 2'b11);
                    chk("ready_in_write", s_ready, 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write_addr", addra, 8'hxx);
                    end else begin
                        e = exp_q.pop_front();
                        chk("addra", addra, e.addr);
                        chk("dina_mode", dina[1027:1024], e.data[1027:1024]);
                        checks++;
                        if (dina[1023:0] !== e.data[1023:0]) begin
                            errors++;
                            bad = 0;
                            for (int k = 0; k < 32; k++) begin
                                if (dina[k*32 +: 32] !== e.data[k*32 +: 32]) begin
                                    bad = k;
                                    break;
                                end
                            end
                            $display("FAIL dina_word addr=%0h word=%0d act=%h exp=%h",
                                     addra, bad, dina[bad*32 +: 32], e.data[bad*32 +: 32]);
                        end
                    end
                    last_wr_cyc = cyc;
                end
                if (start) begin
                    n_start++;
                    chk("start_after_write", cyc - last_wr_cyc, 1);
                end
                if (done) n_done++;
            end
        end
    endtask

    // One beat on the stream; inputs change only 1ns after a rising edge.
    task automatic send_beat(input logic [31:0] d, input logic l, input bit toggle);
        int n;
        if (toggle) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("beat_accept_timeout", 0, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Sends header + 32 data words; the expected row is built from the words.
    task automatic send_row(input int r, input logic [3:0] mode, input bit seq,
                            input bit toggle, input bit final_row, input bit bad_last,
                            input bit push);
        bram_row_t   row;
        logic [31:0] w;
        wr_t         e;
        row = '0;
        row[1027:1024] = mode;
        send_beat({28'($urandom), mode}, 1'b0, toggle);
        for (int k = 0; k < 32; k++) begin
            w = seq ? 32'(k) : $urandom;
            row[k*32 +: 32] = w;
            if (k == 31 && push) begin
                e.addr = 8'(r);
                e.data = row;
                exp_q.push_back(e);
            end
            send_beat(w, (k == 31) && (final_row ^ bad_last), toggle);
        end
    endtask

    task automatic run_job(input int dep, input bit toggle, input bit seq, input int fmode,
                           input bit en_stall, input int bdelay, input int bhold,
                           input bit load_wbh);
        int s0, d0, n;
        logic [3:0] m;
        s0 = n_start;
        d0 = n_done;
        depth = 8'(dep);
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        chk("err_clear_on_load", err, 0);
        if (en_stall) begin
            en = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk("ready_while_stalled", s_ready, 0);
                @(posedge clk); #1;
            end
            en = 1'b1;
        end
        for (int r = 0; r <= dep; r++) begin
            m = (fmode >= 0) ? 4'(fmode) : 4'($urandom);
            send_row(r, m, seq, toggle, r == dep, 1'b0, 1'b1);
        end
        n = 0;
        @(negedge clk);
        while (!start && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", start, 1);
        chk("porta_sel_start", porta_sel, 0);
        @(posedge clk); #1;
        repeat (bdelay) begin
            if (load_wbh) begin
                load  = 1'b1;
                depth = 8'($urandom);
            end
            @(negedge clk);
            chk("porta_sel_wbh", porta_sel, 0);
            @(posedge clk); #1;
            load = 1'b0;
        end
        busy = 1'b1;
        repeat (bhold) begin
            @(negedge clk);
            chk("porta_sel_busy", porta_sel, 0);
            chk("done_early", done, 0);
            @(posedge clk); #1;
        end
        busy = 1'b0;
        @(negedge clk);
        chk("done_before_seen_low", done, 0);
        chk("porta_sel_wbl", porta_sel, 0);
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("porta_sel_done", porta_sel, 1);
        @(negedge clk);
        chk("done_single", done, 0);
        chk("ready_after_done", s_ready, 0);
        if (load_wbh) begin
            repeat (5) begin
                @(negedge clk);
                chk("no_second_job", s_ready, 0);
            end
        end
        chk("start_count", n_start - s0, 1);
        chk("done_count", n_done - d0, 1);
        chk("queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        fork
            monitor();
        join_none
        rst = 1'b1; en = 1'b1; load = 1'b0; depth = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", s_ready, 0);
        chk("rst_cena", cena, 0);
        chk("rst_wea", wea, 0);
        chk("rst_start", start, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_addra", addra, 0);
        chk("rst_porta_sel", porta_sel, 1);
        chk("rst_dina", |dina, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: single row, mode 5, words 0..31, with a brief stall first
        run_job(0, 1'b0, 1'b1, 5, 1'b1, 1, 3, 1'b0);
        // T2: four rows, valid toggling
        run_job(3, 1'b1, 1'b0, -1, 1'b0, 2, 4, 1'b0);
        // T3: long busy
        run_job(1, 1'b0, 1'b0, -1, 1'b0, 0, 10, 1'b0);

        // T4: last asserted on final beat of a non-final row
        s0 = n_start;
        depth = 8'd1;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        send_row(0, 4'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("err_set", err, 1);
        chk("err_idle_ready", s_ready, 0);
        repeat (5) @(negedge clk);
        chk("err_no_start", n_start - s0, 0);
        chk("err_sticky", err, 1);
        @(posedge clk); #1;
        run_job(0, 1'b0, 1'b0, -1, 1'b0, 1, 2, 1'b0);

        // T5: reset in the middle of a row
        s0 = n_start;
        depth = 8'd0;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        send_beat(32'h0000_0003, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) send_beat($urandom, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready", s_ready, 0);
        chk("midrst_cena", cena, 0);
        chk("midrst_addra", addra, 0);
        chk("midrst_porta_sel", porta_sel, 1);
        chk("midrst_err", err, 0);
        chk("midrst_dina", |dina, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_no_start", n_start - s0, 0);
        @(posedge clk); #1;
        run_job(0, 1'b0, 1'b0, -1, 1'b0, 1, 3, 1'b0);

        // T6: load pulses while waiting for busy
        run_job(0, 1'b0, 1'b0, -1, 1'b0, 3, 2, 1'b1);

        // Random jobs
        for (int i = 0; i < 3; i++) begin
            run_job(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0, -1, 1'b0,
                    int'($urandom_range(1, 3)), int'($urandom_range(1, 6)), 1'b0);
        end

        // Full address range without wrap
        run_job(255, 1'b0, 1'b0, -1, 1'b0, 1, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
